// File: rtl/hc_host_mem_responder.sv
// hc_resp_fifo: in-order response queue between a latency pipeline and the Rx port.
// Latency: push is visible at the head on the following cycle; pop takes effect at the clock edge.
// Backpressure: none internally; the caller's in-flight count keeps occupancy <= DEPTH.
module hc_resp_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic         o_empty,
   output logic [W-1:0] o_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;

   // pointer update; the extra MSB distinguishes full from empty
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PTR_ONE;
         if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

   // storage write; contents need no reset because the pointers gate visibility
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
   end

   assign o_empty = (r_wptr == r_rptr);
   assign o_dat   = r_mem[r_rptr[AW-1:0]];
endmodule

// hc_host_mem_responder: host-memory stand-in serving c0 reads / c1 writes from a line memory.
// Latency: RD_LATENCY cycles read accept -> c0 response, WR_LATENCY cycles write accept -> c1 ack, unstalled.
// Backpressure: stalls hold responses queued; almfull from in-flight count; requests at REQ_DEPTH are dropped and flagged.
module hc_host_mem_responder #(
   parameter int ADDR_W        = 10,
   parameter int REQ_DEPTH     = 32,
   parameter int ALMFULL_SLACK = 8,
   parameter int RD_LATENCY    = 4,
   parameter int WR_LATENCY    = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_c0_tx_valid,
   input  logic [41:0]  i_c0_tx_addr,
   input  logic [15:0]  i_c0_tx_mdata,
   input  logic         i_c1_tx_valid,
   input  logic [41:0]  i_c1_tx_addr,
   input  logic [15:0]  i_c1_tx_mdata,
   input  logic [511:0] i_c1_tx_data,
   output logic         o_c0_rx_valid,
   output logic [15:0]  o_c0_rx_mdata,
   output logic [511:0] o_c0_rx_data,
   output logic         o_c1_rx_valid,
   output logic [15:0]  o_c1_rx_mdata,
   output logic         o_c0_tx_almfull,
   output logic         o_c1_tx_almfull,
   input  logic         i_rd_stall,
   input  logic         i_wr_stall,
   output logic         o_overflow_err,
   output logic [31:0]  o_rd_count,
   output logic [31:0]  o_wr_count
);
   localparam int CW = $clog2(REQ_DEPTH) + 1;
   localparam int RS = RD_LATENCY - 1;
   localparam int WS = WR_LATENCY - 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(REQ_DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(REQ_DEPTH - ALMFULL_SLACK);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [511:0]      r_mem [2**ADDR_W];
   logic [CW-1:0]     r_rd_cnt;
   logic [CW-1:0]     r_wr_cnt;
   logic              r_ovf;
   logic [31:0]       r_rd_total;
   logic [31:0]       r_wr_total;

   logic [RS-1:0]     r_rd_pv;
   logic [511:0]      r_rd_pd [RS];
   logic [15:0]       r_rd_pm [RS];
   logic [WS-1:0]     r_wr_pv;
   logic [15:0]       r_wr_pm [WS];

   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_rd_ovf;
   logic              w_wr_ovf;
   logic [ADDR_W-1:0] w_rd_idx;
   logic [ADDR_W-1:0] w_wr_idx;
   logic              w_rd_empty;
   logic              w_wr_empty;
   logic [527:0]      w_rd_head;
   logic [15:0]       w_wr_head;
   logic              w_c0_emit;
   logic              w_c1_emit;
   logic [2*(42-ADDR_W)-1:0] w_unused_addr;

   // Upper address bits alias onto the line index.
   assign w_rd_idx      = i_c0_tx_addr[ADDR_W-1:0];
   assign w_wr_idx      = i_c1_tx_addr[ADDR_W-1:0];
   assign w_unused_addr = {i_c0_tx_addr[41:ADDR_W], i_c1_tx_addr[41:ADDR_W]};

   // Requests during reset are neither accepted nor flagged.
   assign w_rd_acc = i_c0_tx_valid && !i_reset && (r_rd_cnt < FULL_CNT);
   assign w_wr_acc = i_c1_tx_valid && !i_reset && (r_wr_cnt < FULL_CNT);
   assign w_rd_ovf = i_c0_tx_valid && !i_reset && (r_rd_cnt == FULL_CNT);
   assign w_wr_ovf = i_c1_tx_valid && !i_reset && (r_wr_cnt == FULL_CNT);

   // line memory write at the end of the accept cycle; contents survive reset
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) r_mem[w_wr_idx] <= i_c1_tx_data;
   end

   // read pipeline valids, cleared on reset so pre-reset reads never reach the queue
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_pv <= '0;
      end else begin
         r_rd_pv[0] <= w_rd_acc;
         for (int k = 1; k < RS; k++) r_rd_pv[k] <= r_rd_pv[k-1];
      end
   end

   // read payload: memory sampled in the accept cycle (old data on a same-cycle write), then shifted
   always_ff @(posedge i_clk) begin
      r_rd_pd[0] <= r_mem[w_rd_idx];
      r_rd_pm[0] <= i_c0_tx_mdata;
      for (int k = 1; k < RS; k++) begin
         r_rd_pd[k] <= r_rd_pd[k-1];
         r_rd_pm[k] <= r_rd_pm[k-1];
      end
   end

   // write-ack pipeline valids
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_pv <= '0;
      end else begin
         r_wr_pv[0] <= w_wr_acc;
         for (int k = 1; k < WS; k++) r_wr_pv[k] <= r_wr_pv[k-1];
      end
   end

   // write-ack tag shift
   always_ff @(posedge i_clk) begin
      r_wr_pm[0] <= i_c1_tx_mdata;
      for (int k = 1; k < WS; k++) r_wr_pm[k] <= r_wr_pm[k-1];
   end

   hc_resp_fifo #(.W(528), .DEPTH(REQ_DEPTH)) u_rd_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (r_rd_pv[RS-1]),
      .i_dat   ({r_rd_pm[RS-1], r_rd_pd[RS-1]}),
      .i_pop   (w_c0_emit),
      .o_empty (w_rd_empty),
      .o_dat   (w_rd_head)
   );

   hc_resp_fifo #(.W(16), .DEPTH(REQ_DEPTH)) u_wr_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (r_wr_pv[WS-1]),
      .i_dat   (r_wr_pm[WS-1]),
      .i_pop   (w_c1_emit),
      .o_empty (w_wr_empty),
      .o_dat   (w_wr_head)
   );

   // A response leaves whenever the queue head exists and its channel is not stalled.
   assign w_c0_emit = !w_rd_empty && !i_rd_stall && !i_reset;
   assign w_c1_emit = !w_wr_empty && !i_wr_stall && !i_reset;

   // in-flight counters: +1 per accept, -1 per emit
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_rd_acc && !w_c0_emit)      r_rd_cnt <= r_rd_cnt + CNT_ONE;
         else if (!w_rd_acc && w_c0_emit) r_rd_cnt <= r_rd_cnt - CNT_ONE;
         if (w_wr_acc && !w_c1_emit)      r_wr_cnt <= r_wr_cnt + CNT_ONE;
         else if (!w_wr_acc && w_c1_emit) r_wr_cnt <= r_wr_cnt - CNT_ONE;
      end
   end

   // sticky overflow flag and free-running acceptance totals
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ovf      <= 1'b0;
         r_rd_total <= '0;
         r_wr_total <= '0;
      end else begin
         if (w_rd_ovf || w_wr_ovf) r_ovf <= 1'b1;
         if (w_rd_acc) r_rd_total <= r_rd_total + 32'd1;
         if (w_wr_acc) r_wr_total <= r_wr_total + 32'd1;
      end
   end

   assign o_c0_rx_valid   = w_c0_emit;
   assign o_c0_rx_mdata   = w_c0_emit ? w_rd_head[527:512] : 16'h0;
   assign o_c0_rx_data    = w_c0_emit ? w_rd_head[511:0]   : 512'h0;
   assign o_c1_rx_valid   = w_c1_emit;
   assign o_c1_rx_mdata   = w_c1_emit ? w_wr_head : 16'h0;
   assign o_c0_tx_almfull = (r_rd_cnt >= AF_CNT);
   assign o_c1_tx_almfull = (r_wr_cnt >= AF_CNT);
   assign o_overflow_err  = r_ovf;
   assign o_rd_count      = r_rd_total;
   assign o_wr_count      = r_wr_total;
endmodule

// File: tb/tb_hc_host_mem_responder.sv
// tb_hc_host_mem_responder: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: model holds each response with the cycle it becomes eligible (accept + latency).
// Backpressure: stalls and resets are driven randomly; the model decides every output each cycle.
module tb_hc_host_mem_responder;
   localparam int LAT_RD = 4;
   localparam int LAT_WR = 2;
   localparam int DEPTH  = 32;
   localparam int AF_LVL = 24;
   localparam int NLINES = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, c0_tx_valid, c1_tx_valid, rd_stall, wr_stall;
   logic [41:0]  c0_tx_addr, c1_tx_addr;
   logic [15:0]  c0_tx_mdata, c1_tx_mdata;
   logic [511:0] c1_tx_data;
   logic         c0_rx_valid, c1_rx_valid, c0_tx_almfull, c1_tx_almfull, overflow_err;
   logic [15:0]  c0_rx_mdata, c1_rx_mdata;
   logic [511:0] c0_rx_data;
   logic [31:0]  rd_count, wr_count;

   hc_host_mem_responder dut (
      .i_clk(clk), .i_reset(reset),
      .i_c0_tx_valid(c0_tx_valid), .i_c0_tx_addr(c0_tx_addr), .i_c0_tx_mdata(c0_tx_mdata),
      .i_c1_tx_valid(c1_tx_valid), .i_c1_tx_addr(c1_tx_addr), .i_c1_tx_mdata(c1_tx_mdata),
      .i_c1_tx_data(c1_tx_data),
      .o_c0_rx_valid(c0_rx_valid), .o_c0_rx_mdata(c0_rx_mdata), .o_c0_rx_data(c0_rx_data),
      .o_c1_rx_valid(c1_rx_valid), .o_c1_rx_mdata(c1_rx_mdata),
      .o_c0_tx_almfull(c0_tx_almfull), .o_c1_tx_almfull(c1_tx_almfull),
      .i_rd_stall(rd_stall), .i_wr_stall(wr_stall),
      .o_overflow_err(overflow_err), .o_rd_count(rd_count), .o_wr_count(wr_count)
   );

   typedef struct {
      logic [15:0]  m;
      logic [511:0] d;
      int           rdy;
   } rsp_t;

   rsp_t         q0[$];
   rsp_t         q1[$];
   logic [511:0] mmem [NLINES];
   logic         m_ovf;
   logic [31:0]  m_rdt, m_wrt;

   // stimulus for the next cycle
   logic         s_rst, s_rd_v, s_wr_v, s_rd_st, s_wr_st;
   logic [41:0]  s_rd_a, s_wr_a;
   logic [15:0]  s_rd_m, s_wr_m;
   logic [511:0] s_wr_d;

   // observations captured from the DUT
   int           cyc, n_vec, n_err, n_rx0, n_rx1;
   int           rx0_cyc [int];
   logic [511:0] rx0_dat [int];
   int           rx1_cyc [int];
   logic [15:0]  last_m0;
   logic         cap_af0, cap_ovf;
   logic [31:0]  cap_rdcnt, cap_wrcnt;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step();
      rsp_t r;
      logic e0v, e1v;
      int   n0, n1;
      @(negedge clk);
      reset = s_rst;  rd_stall = s_rd_st;  wr_stall = s_wr_st;
      c0_tx_valid = s_rd_v;  c0_tx_addr = s_rd_a;  c0_tx_mdata = s_rd_m;
      c1_tx_valid = s_wr_v;  c1_tx_addr = s_wr_a;  c1_tx_mdata = s_wr_m;  c1_tx_data = s_wr_d;
      #1;
      n0 = q0.size();
      n1 = q1.size();
      e0v = 1'b0;
      e1v = 1'b0;
      if (!s_rst && !s_rd_st && n0 > 0) e0v = (q0[0].rdy <= cyc);
      if (!s_rst && !s_wr_st && n1 > 0) e1v = (q1[0].rdy <= cyc);

      chk("c0_rx_valid", c0_rx_valid, e0v);
      if (e0v) begin
         chk("c0_rx_mdata", c0_rx_mdata, q0[0].m);
         chk("c0_rx_data", c0_rx_data, q0[0].d);
      end
      chk("c1_rx_valid", c1_rx_valid, e1v);
      if (e1v) chk("c1_rx_mdata", c1_rx_mdata, q1[0].m);
      if (!s_rst) begin
         chk("c0_tx_almfull", c0_tx_almfull, n0 >= AF_LVL);
         chk("c1_tx_almfull", c1_tx_almfull, n1 >= AF_LVL);
         chk("overflow_err", overflow_err, m_ovf);
         chk("rd_count", rd_count, m_rdt);
         chk("wr_count", wr_count, m_wrt);
      end

      if (c0_rx_valid) begin
         rx0_cyc[int'(c0_rx_mdata)] = cyc;
         rx0_dat[int'(c0_rx_mdata)] = c0_rx_data;
         last_m0 = c0_rx_mdata;
         n_rx0++;
      end
      if (c1_rx_valid) begin
         rx1_cyc[int'(c1_rx_mdata)] = cyc;
         n_rx1++;
      end
      cap_af0 = c0_tx_almfull;  cap_ovf = overflow_err;
      cap_rdcnt = rd_count;     cap_wrcnt = wr_count;

      if (s_rst) begin
         q0.delete();  q1.delete();
         m_ovf = 1'b0;  m_rdt = '0;  m_wrt = '0;
      end else begin
         if (e0v) void'(q0.pop_front());
         if (e1v) void'(q1.pop_front());
         if (s_rd_v) begin
            if (n0 < DEPTH) begin
               r.m = s_rd_m;  r.d = mmem[s_rd_a[9:0]];  r.rdy = cyc + LAT_RD;
               q0.push_back(r);
               m_rdt++;
            end else m_ovf = 1'b1;
         end
         if (s_wr_v) begin
            if (n1 < DEPTH) begin
               r.m = s_wr_m;  r.d = '0;  r.rdy = cyc + LAT_WR;
               q1.push_back(r);
               mmem[s_wr_a[9:0]] = s_wr_d;
               m_wrt++;
            end else m_ovf = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic go(input logic rv, input logic [41:0] ra, input logic [15:0] rm,
                     input logic wv, input logic [41:0] wa, input logic [15:0] wm,
                     input logic [511:0] wd);
      s_rd_v = rv;  s_rd_a = ra;  s_rd_m = rm;
      s_wr_v = wv;  s_wr_a = wa;  s_wr_m = wm;  s_wr_d = wd;
      step();
      s_rd_v = 1'b0;
      s_wr_v = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) go(1'b0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      logic [511:0] pat_a5, pat_ff, wdat;
      logic [41:0]  ra, wa;
      int           t0, tr, fall, nr, snap;
      pat_a5 = {64{8'hA5}};
      pat_ff = {64{8'hFF}};
      cyc = 0;  n_vec = 0;  n_err = 0;  n_rx0 = 0;  n_rx1 = 0;  last_m0 = '0;
      m_ovf = 1'b0;  m_rdt = '0;  m_wrt = '0;
      for (int i = 0; i < NLINES; i++) mmem[i] = '0;
      s_rst = 1'b1;  s_rd_st = 1'b0;  s_wr_st = 1'b0;
      s_rd_v = 1'b0; s_wr_v = 1'b0; s_rd_a = '0; s_wr_a = '0; s_rd_m = '0; s_wr_m = '0; s_wr_d = '0;
      reset = 1'b1;  rd_stall = 1'b0;  wr_stall = 1'b0;
      c0_tx_valid = 1'b0;  c0_tx_addr = '0;  c0_tx_mdata = '0;
      c1_tx_valid = 1'b0;  c1_tx_addr = '0;  c1_tx_mdata = '0;  c1_tx_data = '0;

      // reset state
      idle(3);
      s_rst = 1'b0;
      idle(1);
      chk("reset_rd_count", cap_rdcnt, 32'd0);
      chk("reset_almfull", cap_af0, 1'b0);
      chk("reset_overflow", cap_ovf, 1'b0);
      chk("reset_no_rsp", 32'(n_rx0 + n_rx1), 32'd0);

      // give every line a known value
      for (int i = 0; i < NLINES; i++) go(1'b0, '0, '0, 1'b1, 42'(i), 16'(i), '0);
      idle(4);

      // write then read two cycles later
      t0 = cyc;
      go(1'b0, '0, '0, 1'b1, 42'd3, 16'h11, pat_a5);
      idle(1);
      go(1'b1, 42'd3, 16'h22, 1'b0, '0, '0, '0);
      idle(6);
      chk("wr_ack_latency", 32'(rx1_cyc[16'h11]), 32'(t0 + 2));
      chk("rd_latency", 32'(rx0_cyc[16'h22]), 32'(t0 + 6));
      chk("rd_data_a5", rx0_dat[16'h22], pat_a5);

      // same-cycle read and write, then read-after-write
      go(1'b1, 42'd7, 16'h33, 1'b1, 42'd7, 16'h44, pat_ff);
      go(1'b1, 42'd7, 16'h34, 1'b0, '0, '0, '0);
      idle(6);
      chk("rbw_old_data", rx0_dat[16'h33], 512'd0);
      chk("raw_new_data", rx0_dat[16'h34], pat_ff);

      // back-to-back reads from a clean reset
      s_rst = 1'b1;  idle(1);  s_rst = 1'b0;
      t0 = cyc;
      for (int k = 0; k < 10; k++) go(1'b1, 42'($urandom_range(0, 1023)), 16'(k), 1'b0, '0, '0, '0);
      idle(6);
      for (int k = 0; k < 10; k++) chk("b2b_latency", 32'(rx0_cyc[k]), 32'(t0 + 4 + k));
      chk("b2b_rd_count", cap_rdcnt, 32'd10);

      // fill under stall: almfull at 24, overflow past 32, drain in order
      s_rd_st = 1'b1;
      for (int i = 0; i < 24; i++) go(1'b1, 42'(i), 16'(100 + i), 1'b0, '0, '0, '0);
      chk("almfull_at_23", cap_af0, 1'b0);
      idle(1);
      chk("almfull_at_24", cap_af0, 1'b1);
      for (int i = 0; i < 9; i++) go(1'b1, 42'(i), 16'(124 + i), 1'b0, '0, '0, '0);
      idle(1);
      chk("overflow_set", cap_ovf, 1'b1);
      chk("fill_rd_count", cap_rdcnt, 32'd42);
      s_rd_st = 1'b0;
      tr = cyc;  nr = n_rx0;  fall = -1;
      for (int i = 0; i < 40; i++) begin
         idle(1);
         if (fall < 0 && !cap_af0) fall = cyc - 1;
      end
      chk("almfull_fall_cycle", 32'(fall), 32'(tr + 9));
      chk("drain_count", 32'(n_rx0 - nr), 32'd32);
      chk("drain_last_mdata", last_m0, 16'd131);

      // address aliasing above the line-index width
      wdat = rnd512();
      go(1'b0, '0, '0, 1'b1, 42'h400, 16'h55, wdat);
      go(1'b1, 42'h0, 16'h56, 1'b0, '0, '0, '0);
      idle(6);
      chk("alias_data", rx0_dat[16'h56], wdat);

      // reset with reads in flight
      s_rd_st = 1'b1;
      for (int i = 0; i < 5; i++) go(1'b1, 42'(i), 16'(200 + i), 1'b0, '0, '0, '0);
      s_rst = 1'b1;  s_rd_st = 1'b0;
      idle(1);
      s_rst = 1'b0;
      snap = n_rx0;
      idle(10);
      chk("rst_no_rsp", 32'(n_rx0 - snap), 32'd0);
      chk("rst_almfull", cap_af0, 1'b0);
      chk("rst_rd_count", cap_rdcnt, 32'd0);
      chk("rst_wr_count", cap_wrcnt, 32'd0);
      chk("rst_overflow", cap_ovf, 1'b0);

      // randomized traffic with stall-heavy phases and occasional reset
      for (int i = 0; i < 3000; i++) begin
         if ((i / 150) % 2 == 1) begin
            s_rd_st = ($urandom_range(0, 9) != 0);
            s_wr_st = ($urandom_range(0, 9) != 0);
         end else begin
            s_rd_st = ($urandom_range(0, 3) == 0);
            s_wr_st = ($urandom_range(0, 3) == 0);
         end
         s_rst = ($urandom_range(0, 999) == 0);
         ra = 42'({$urandom(), $urandom()});
         wa = 42'({$urandom(), $urandom()});
         ra[9:0] = 10'($urandom_range(0, 15));
         wa[9:0] = 10'($urandom_range(0, 15));
         go(($urandom_range(0, 3) != 0), ra, 16'($urandom()),
            ($urandom_range(0, 3) != 0), wa, 16'($urandom()), rnd512());
      end
      s_rst = 1'b0;  s_rd_st = 1'b0;  s_wr_st = 1'b0;
      idle(50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
